// File: rtl/pixel_position_gen.sv
// Tracks the 1-based (x, y) position of each accepted pixel on a video stream
// and flags line/frame protocol violations; all outputs are registered.
module pixel_position_gen #(
    parameter int FRAME_WIDTH  = 1280,
    parameter int FRAME_HEIGHT = 720
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_valid,
    input  logic        pix_sof,
    input  logic        pix_eol,
    input  logic        err_clr,
    output logic [11:0] x_pos,
    output logic [10:0] y_pos,
    output logic        pos_valid,
    output logic        center_vsync,
    output logic [15:0] frame_cnt,
    output logic        line_err,
    output logic        frame_err
);

    localparam logic [11:0] W = 12'(FRAME_WIDTH);
    localparam logic [10:0] H = 11'(FRAME_HEIGHT);

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        ACTIVE   = 2'd1,
        VBLANK   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] xc_q, xc_d;
    logic [10:0] yc_q, yc_d;
    logic        closed_q, closed_d;
    logic [11:0] x_pos_q, x_pos_d;
    logic [10:0] y_pos_q, y_pos_d;
    logic        pos_valid_q, pos_valid_d;
    logic        center_vsync_q, center_vsync_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        line_err_q, line_err_d;
    logic        frame_err_q, frame_err_d;
    logic        line_set, frame_set;

    logic        sof_px;
    logic        frame_done;
    logic        overrun_last;
    logic [11:0] xc_inc;
    logic [10:0] yc_inc;

    assign sof_px       = pix_valid & pix_sof;
    // Last line has been closed; the FSM leaves ACTIVE one cycle after that pixel is presented.
    assign frame_done   = (state_q == ACTIVE) && closed_q && (yc_q == H);
    assign overrun_last = (state_q == ACTIVE) && !closed_q && (xc_q == W) && (yc_q == H);
    assign xc_inc       = xc_q + 12'd1;
    assign yc_inc       = yc_q + 11'd1;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_SOF;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (sof_px) begin
            state_d = ACTIVE;
        end else begin
            case (state_q)
                ACTIVE: begin
                    if (frame_done || (pix_valid && overrun_last)) begin
                        state_d = VBLANK;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Output / datapath logic
    always_comb begin
        xc_d        = xc_q;
        yc_d        = yc_q;
        closed_d    = closed_q;
        x_pos_d     = 12'd0;
        y_pos_d     = 11'd0;
        pos_valid_d = 1'b0;
        frame_cnt_d = frame_cnt_q;
        line_set    = 1'b0;
        frame_set   = 1'b0;

        if (sof_px) begin
            xc_d        = 12'd1;
            yc_d        = 11'd1;
            closed_d    = pix_eol;
            x_pos_d     = 12'd1;
            y_pos_d     = 11'd1;
            pos_valid_d = 1'b1;
            frame_cnt_d = frame_cnt_q + 16'd1;
            frame_set   = (state_q == ACTIVE) && !frame_done;
            line_set    = pix_eol && (W != 12'd1);
        end else if (pix_valid) begin
            case (state_q)
                ACTIVE: begin
                    if (frame_done) begin
                        frame_set = 1'b1;
                    end else if (overrun_last) begin
                        // No line left to wrap into: the pixel is dropped.
                        line_set = 1'b1;
                    end else if (closed_q || (xc_q == W)) begin
                        line_set    = !closed_q || (pix_eol && (W != 12'd1));
                        xc_d        = 12'd1;
                        yc_d        = yc_inc;
                        closed_d    = pix_eol;
                        x_pos_d     = 12'd1;
                        y_pos_d     = yc_inc;
                        pos_valid_d = 1'b1;
                    end else begin
                        line_set    = pix_eol && (xc_inc != W);
                        xc_d        = xc_inc;
                        closed_d    = pix_eol;
                        x_pos_d     = xc_inc;
                        y_pos_d     = yc_q;
                        pos_valid_d = 1'b1;
                    end
                end
                VBLANK:  frame_set = 1'b1;
                default: frame_set = 1'b0;
            endcase
        end

        center_vsync_d = (state_d != ACTIVE);
        line_err_d     = err_clr ? 1'b0 : (line_err_q | line_set);
        frame_err_d    = err_clr ? 1'b0 : (frame_err_q | frame_set);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xc_q           <= 12'd0;
            yc_q           <= 11'd0;
            closed_q       <= 1'b0;
            x_pos_q        <= 12'd0;
            y_pos_q        <= 11'd0;
            pos_valid_q    <= 1'b0;
            center_vsync_q <= 1'b1;
            frame_cnt_q    <= 16'd0;
            line_err_q     <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            xc_q           <= xc_d;
            yc_q           <= yc_d;
            closed_q       <= closed_d;
            x_pos_q        <= x_pos_d;
            y_pos_q        <= y_pos_d;
            pos_valid_q    <= pos_valid_d;
            center_vsync_q <= center_vsync_d;
            frame_cnt_q    <= frame_cnt_d;
            line_err_q     <= line_err_d;
            frame_err_q    <= frame_err_d;
        end
    end

    assign x_pos        = x_pos_q;
    assign y_pos        = y_pos_q;
    assign pos_valid    = pos_valid_q;
    assign center_vsync = center_vsync_q;
    assign frame_cnt    = frame_cnt_q;
    assign line_err     = line_err_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_pixel_position_gen.sv
// Directed bench for pixel_position_gen with a 4x3 frame.
module tb_pixel_position_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pix_valid = 1'b0;
    logic        pix_sof = 1'b0;
    logic        pix_eol = 1'b0;
    logic        err_clr = 1'b0;
    logic [11:0] x_pos;
    logic [10:0] y_pos;
    logic        pos_valid;
    logic        center_vsync;
    logic [15:0] frame_cnt;
    logic        line_err;
    logic        frame_err;

    int n_vec = 0;
    int n_err = 0;

    pixel_position_gen #(
        .FRAME_WIDTH (4),
        .FRAME_HEIGHT(3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_valid   (pix_valid),
        .pix_sof     (pix_sof),
        .pix_eol     (pix_eol),
        .err_clr     (err_clr),
        .x_pos       (x_pos),
        .y_pos       (y_pos),
        .pos_valid   (pos_valid),
        .center_vsync(center_vsync),
        .frame_cnt   (frame_cnt),
        .line_err    (line_err),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    // Apply one cycle of inputs; on return the outputs reflect that cycle.
    task automatic tick(input logic v, input logic sof, input logic eol, input logic clr);
        pix_valid = v;
        pix_sof   = sof;
        pix_eol   = eol;
        err_clr   = clr;
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        pix_eol   = 1'b0;
        err_clr   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (x_pos !== 12'd0) begin n_err++; $display("FAIL reset_x: got %0d want 0", x_pos); end
        n_vec++; if (y_pos !== 11'd0) begin n_err++; $display("FAIL reset_y: got %0d want 0", y_pos); end
        n_vec++; if (pos_valid !== 1'b0) begin n_err++; $display("FAIL reset_pv: got %b want 0", pos_valid); end
        n_vec++; if (center_vsync !== 1'b1) begin n_err++; $display("FAIL reset_vs: got %b want 1", center_vsync); end
        n_vec++; if (frame_cnt !== 16'd0) begin n_err++; $display("FAIL reset_fc: got %0d want 0", frame_cnt); end
        n_vec++; if (line_err !== 1'b0) begin n_err++; $display("FAIL reset_le: got %b want 0", line_err); end
        n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_fe: got %b want 0", frame_err); end
    endtask

    task automatic test_contiguous();
        logic [23:0] exp;
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, i == 0, (i % 4) == 3, 1'b0);
            exp = {1'b1, 11'(i / 4 + 1), 12'(i % 4 + 1)};
            n_vec++;
            if ({pos_valid, y_pos, x_pos} !== exp) begin
                n_err++; $display("FAIL contig_pos[%0d]: got %h want %h", i, {pos_valid, y_pos, x_pos}, exp);
            end
            n_vec++; if (center_vsync !== 1'b0) begin n_err++; $display("FAIL contig_vs[%0d]: got %b want 0", i, center_vsync); end
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        n_vec++; if (center_vsync !== 1'b1) begin n_err++; $display("FAIL contig_vs_after: got %b want 1", center_vsync); end
        n_vec++; if ({pos_valid, y_pos, x_pos} !== 24'd0) begin n_err++; $display("FAIL contig_idle_pos: got %h want 0", {pos_valid, y_pos, x_pos}); end
        n_vec++; if (frame_cnt !== 16'd1) begin n_err++; $display("FAIL contig_fc: got %0d want 1", frame_cnt); end
        n_vec++; if ({line_err, frame_err} !== 2'b00) begin n_err++; $display("FAIL contig_errs: got %b want 00", {line_err, frame_err}); end
    endtask

    task automatic test_gaps();
        logic [23:0] exp;
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, i == 0, (i % 4) == 3, 1'b0);
            exp = {1'b1, 11'(i / 4 + 1), 12'(i % 4 + 1)};
            n_vec++;
            if ({pos_valid, y_pos, x_pos} !== exp) begin
                n_err++; $display("FAIL gap_pos[%0d]: got %h want %h", i, {pos_valid, y_pos, x_pos}, exp);
            end
            for (int g = 0; g < 2; g++) begin
                tick(1'b0, 1'b0, 1'b0, 1'b0);
                n_vec++;
                if ({pos_valid, y_pos, x_pos} !== 24'd0) begin
                    n_err++; $display("FAIL gap_idle[%0d.%0d]: got %h want 0", i, g, {pos_valid, y_pos, x_pos});
                end
            end
        end
        n_vec++; if (center_vsync !== 1'b1) begin n_err++; $display("FAIL gap_vs_after: got %b want 1", center_vsync); end
        n_vec++; if (frame_cnt !== 16'd2) begin n_err++; $display("FAIL gap_fc: got %0d want 2", frame_cnt); end
        n_vec++; if ({line_err, frame_err} !== 2'b00) begin n_err++; $display("FAIL gap_errs: got %b want 00", {line_err, frame_err}); end
    endtask

    task automatic test_line_err_early();
        do_reset();
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        n_vec++; if (line_err !== 1'b1) begin n_err++; $display("FAIL early_eol_le: got %b want 1", line_err); end
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        n_vec++; if ({pos_valid, y_pos, x_pos} !== {1'b1, 11'd2, 12'd1}) begin n_err++; $display("FAIL early_eol_next: got %h want %h", {pos_valid, y_pos, x_pos}, {1'b1, 11'd2, 12'd1}); end
    endtask

    task automatic test_line_overrun();
        do_reset();
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
        n_vec++; if (line_err !== 1'b0) begin n_err++; $display("FAIL overrun_pre_le: got %b want 0", line_err); end
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        n_vec++; if ({pos_valid, y_pos, x_pos} !== {1'b1, 11'd2, 12'd1}) begin n_err++; $display("FAIL overrun_pos: got %h want %h", {pos_valid, y_pos, x_pos}, {1'b1, 11'd2, 12'd1}); end
        n_vec++; if (line_err !== 1'b1) begin n_err++; $display("FAIL overrun_le: got %b want 1", line_err); end
    endtask

    task automatic test_sof_eol();
        do_reset();
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        n_vec++; if ({pos_valid, y_pos, x_pos} !== {1'b1, 11'd1, 12'd1}) begin n_err++; $display("FAIL sofeol_pos: got %h want %h", {pos_valid, y_pos, x_pos}, {1'b1, 11'd1, 12'd1}); end
        n_vec++; if (line_err !== 1'b1) begin n_err++; $display("FAIL sofeol_le: got %b want 1", line_err); end
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        n_vec++; if ({pos_valid, y_pos, x_pos} !== {1'b1, 11'd2, 12'd1}) begin n_err++; $display("FAIL sofeol_next: got %h want %h", {pos_valid, y_pos, x_pos}, {1'b1, 11'd2, 12'd1}); end
    endtask

    task automatic test_mid_frame_sof();
        do_reset();
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        n_vec++; if ({pos_valid, y_pos, x_pos} !== {1'b1, 11'd1, 12'd1}) begin n_err++; $display("FAIL midsof_pos: got %h want %h", {pos_valid, y_pos, x_pos}, {1'b1, 11'd1, 12'd1}); end
        n_vec++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL midsof_fe: got %b want 1", frame_err); end
        n_vec++; if (frame_cnt !== 16'd2) begin n_err++; $display("FAIL midsof_fc: got %0d want 2", frame_cnt); end
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        n_vec++; if ({line_err, frame_err} !== 2'b00) begin n_err++; $display("FAIL clr_prio_errs: got %b want 00", {line_err, frame_err}); end
        n_vec++; if (frame_cnt !== 16'd3) begin n_err++; $display("FAIL clr_prio_fc: got %0d want 3", frame_cnt); end
    endtask

    task automatic test_vblank_and_rst();
        do_reset();
        for (int i = 0; i < 12; i++) tick(1'b1, i == 0, (i % 4) == 3, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        n_vec++; if ({pos_valid, y_pos, x_pos} !== 24'd0) begin n_err++; $display("FAIL vblank_pos: got %h want 0", {pos_valid, y_pos, x_pos}); end
        n_vec++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL vblank_fe: got %b want 1", frame_err); end
        do_reset();
        for (int i = 0; i < 7; i++) tick(1'b1, i == 0, i == 3, 1'b0);
        n_vec++; if ({pos_valid, y_pos, x_pos} !== {1'b1, 11'd2, 12'd3}) begin n_err++; $display("FAIL rstmid_pre: got %h want %h", {pos_valid, y_pos, x_pos}, {1'b1, 11'd2, 12'd3}); end
        rst = 1'b1;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        n_vec++; if ({pos_valid, y_pos, x_pos} !== 24'd0) begin n_err++; $display("FAIL rstmid_pos: got %h want 0", {pos_valid, y_pos, x_pos}); end
        n_vec++; if (center_vsync !== 1'b1) begin n_err++; $display("FAIL rstmid_vs: got %b want 1", center_vsync); end
        n_vec++; if (frame_cnt !== 16'd0) begin n_err++; $display("FAIL rstmid_fc: got %0d want 0", frame_cnt); end
        n_vec++; if ({line_err, frame_err} !== 2'b00) begin n_err++; $display("FAIL rstmid_errs: got %b want 00", {line_err, frame_err}); end
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 1'b0, i == 1, 1'b0);
            n_vec++; if ({pos_valid, y_pos, x_pos} !== 24'd0) begin n_err++; $display("FAIL waitsof_pos[%0d]: got %h want 0", i, {pos_valid, y_pos, x_pos}); end
            n_vec++; if ({line_err, frame_err} !== 2'b00) begin n_err++; $display("FAIL waitsof_errs[%0d]: got %b want 00", i, {line_err, frame_err}); end
        end
    endtask

    task automatic test_frame_cnt_wrap();
        do_reset();
        for (int i = 0; i < 65535; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
        n_vec++; if (frame_cnt !== 16'hFFFF) begin n_err++; $display("FAIL wrap_ffff: got %h want ffff", frame_cnt); end
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        n_vec++; if (frame_cnt !== 16'd1) begin n_err++; $display("FAIL wrap_one: got %h want 0001", frame_cnt); end
    endtask

    initial begin
        test_reset();
        test_contiguous();
        test_gaps();
        test_line_err_early();
        test_line_overrun();
        test_sof_eol();
        test_mid_frame_sof();
        test_vblank_and_rst();
        test_frame_cnt_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pixel_position_gen.md
PIXEL_POSITION_GEN -- requirements
Module: pixel_position_gen

Interface
REQ-001 SHALL have parameter FRAME_WIDTH, default 1280, active pixels per line (range 2..4095).
REQ-002 SHALL have parameter FRAME_HEIGHT, default 720, active lines per frame (range 2..2047).
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port pix_valid  input  1  one pixel accepted on the video stream this cycle.
REQ-006 SHALL have port pix_sof  input  1  start-of-frame marker, qualified by pix_valid.
REQ-007 SHALL have port pix_eol  input  1  end-of-line marker, qualified by pix_valid.
REQ-008 SHALL have port err_clr  input  1  clears sticky error flags.
REQ-009 SHALL have port x_pos  output  12  1-based column of the presented pixel, 0 when pos_valid=0.
REQ-010 SHALL have port y_pos  output  11  1-based line of the presented pixel, 0 when pos_valid=0.
REQ-011 SHALL have port pos_valid  output  1  x_pos/y_pos refer to an accepted pixel.
REQ-012 SHALL have port center_vsync  output  1  high outside the active frame (between frames).
REQ-013 SHALL have port frame_cnt  output  16  count of accepted SOFs, wraps modulo 2^16.
REQ-014 SHALL have ports line_err, frame_err  output  1 each  sticky protocol error flags.

Function
REQ-015 SHALL implement states WAIT_SOF, ACTIVE, VBLANK; internal column counter xc and line counter yc.
REQ-016 SHALL register all outputs; pixel accepted in cycle N is presented (x_pos, y_pos, pos_valid=1) in cycle N+1.
REQ-017 SHALL, in WAIT_SOF, ignore valid pixels without pix_sof (pos_valid stays 0, no error).
REQ-018 SHALL, on valid pixel with pix_sof in any state, present (1,1), set xc=1/yc=1, enter ACTIVE, increment frame_cnt.
REQ-019 SHALL set frame_err if pix_sof arrives in ACTIVE (mid-frame restart); position still restarts at (1,1).
REQ-020 SHALL, in ACTIVE on valid non-SOF pixel, present xc+1 on the same line unless previous pixel closed the line.
REQ-021 SHALL close a line on pix_eol: next accepted pixel presents x=1, y=yc+1.
REQ-022 SHALL set line_err when pix_eol arrives with xc != FRAME_WIDTH, or when a pixel would reach xc=FRAME_WIDTH+1 without eol; in the latter case SHALL wrap to x=1, y=yc+1.
REQ-023 SHALL, on pixel closing line FRAME_HEIGHT, enter VBLANK the following cycle; center_vsync SHALL rise in cycle N+2 (one cycle after that pixel's pos_valid).
REQ-024 SHALL hold center_vsync=1 in WAIT_SOF and VBLANK, and drop it in the same cycle the SOF pixel is presented (N+1).
REQ-025 SHALL, in VBLANK, ignore valid non-SOF pixels (pos_valid=0) and set frame_err.
REQ-026 SHALL leave x_pos=0, y_pos=0, pos_valid=0 in every cycle without a presented pixel; no stall, gaps between pixels are arbitrary.
REQ-027 SHALL give err_clr priority over a same-cycle error set (flags read 0 next cycle).
REQ-028 SHALL treat pix_sof and pix_eol on the same pixel as SOF at (1,1) followed by line close (line_err set, since FRAME_WIDTH>=2).

Reset
REQ-029 SHALL, on rst=1, enter WAIT_SOF; next cycle x_pos=0, y_pos=0, pos_valid=0, center_vsync=1, frame_cnt=0, line_err=0, frame_err=0.
REQ-030 SHALL give rst priority over all inputs; rst mid-frame abandons the frame with no error flagged.

Verification (FRAME_WIDTH=4, FRAME_HEIGHT=3)
REQ-031 SHALL cover: rst, then 12 contiguous pixels, SOF on first, eol every 4th -> positions (1,1)..(4,3) in order, pos_valid 12 cycles, center_vsync 0 during frame, 1 cycle after (4,3), frame_cnt=1, no errors.
REQ-032 SHALL cover: same frame with 2-cycle gaps between pixels -> identical position sequence, x_pos/y_pos=0 in gap cycles.
REQ-033 SHALL cover: eol on 3rd pixel of line 1 -> line_err=1, next pixel (1,2); 5th pixel without eol -> presented (1,2), line_err=1.
REQ-034 SHALL cover: SOF at pixel (2,2) -> presented (1,1), frame_err=1, frame_cnt increments; err_clr with concurrent error -> flags 0.
REQ-035 SHALL cover: non-SOF pixel in VBLANK -> pos_valid=0, frame_err=1; rst at (3,2) -> outputs reset values, next non-SOF pixels ignored.
REQ-036 SHALL cover: 65537 SOFs -> frame_cnt wraps to 1.
